// File: rtl/nonce_scheduler.sv
// Nonce scheduler: sweeps nonces 0..NONCE_LAST of a captured header job into a hash core.
// Define NONCE_SCHEDULER_EARLY_ABORT_EN to end a job at its first reported hit.
module nonce_scheduler #(
  parameter logic [31:0] NONCE_LAST      = 32'hFFFF_FFFF,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sr_full,
  input  logic [351:0] sr_data,
  output logic         sr_read,
  output logic         core_valid,
  input  logic         core_ready,
  output logic [351:0] core_data,
  input  logic         core_result_valid,
  input  logic         core_hit,
  input  logic [31:0]  core_result_nonce,
  input  logic         abort,
  output logic         found_valid,
  output logic [31:0]  found_nonce,
  output logic         job_done,
  output logic [7:0]   hit_count
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);

  state_t       state;
  state_t       state_nx;
  logic [319:0] job;
  logic [31:0]  nonce;
  logic [2:0]   outst;
  logic [2:0]   outst_nx;
  logic         in_job;
  logic         res_hit;
  logic         hit_ok;
  logic         early_stop;
  logic         stop;
  logic         xfer;
  logic         res_dec;
  logic         last_xfer;
  logic         sr_tail_unused;

  // The low word of the header is replaced by the nonce.
  assign sr_tail_unused = ^sr_data[31:0];

  assign in_job  = (state == ISSUE) || (state == DRAIN);
  assign res_hit = core_result_valid & core_hit & in_job;

`ifdef NONCE_SCHEDULER_EARLY_ABORT_EN
  logic hit_seen;
  assign hit_ok     = res_hit & ~hit_seen;
  assign early_stop = hit_ok & (state == ISSUE);
`else
  assign hit_ok     = res_hit;
  assign early_stop = 1'b0;
`endif

  assign stop      = abort | early_stop;
  assign xfer      = core_valid & core_ready;
  assign last_xfer = xfer && (nonce == NONCE_LAST);
  // Results with nothing in flight are stray and must not underflow.
  assign res_dec   = core_result_valid & (outst != 3'd0);
  assign outst_nx  = outst + {2'b00, xfer} - {2'b00, res_dec};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (sr_full) state_nx = ISSUE;
      end
      ISSUE: begin
        if (stop || last_xfer) state_nx = DRAIN;
      end
      DRAIN: begin
        if (outst_nx == 3'd0) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sr_read    = 1'b0;
    core_valid = 1'b0;
    job_done   = 1'b0;
    unique case (state)
      IDLE:    sr_read = rst_n & sr_full;
      ISSUE:   core_valid = (outst < MAX_OUT) & ~stop;
      DRAIN:   core_valid = 1'b0;
      DONE:    job_done = 1'b1;
      default: sr_read = 1'b0;
    endcase
  end

  assign core_data = {job, nonce};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job         <= '0;
      nonce       <= '0;
      outst       <= '0;
      hit_count   <= '0;
      found_valid <= 1'b0;
      found_nonce <= '0;
`ifdef NONCE_SCHEDULER_EARLY_ABORT_EN
      hit_seen    <= 1'b0;
`endif
    end else begin
      outst       <= outst_nx;
      found_valid <= hit_ok;
      if (sr_read) begin
        job       <= sr_data[351:32];
        nonce     <= '0;
        hit_count <= '0;
`ifdef NONCE_SCHEDULER_EARLY_ABORT_EN
        hit_seen  <= 1'b0;
`endif
      end else begin
        // The last nonce is held rather than wrapped.
        if (xfer && !last_xfer) nonce <= nonce + 32'd1;
        if (hit_ok) begin
          found_nonce <= core_result_nonce;
          if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
`ifdef NONCE_SCHEDULER_EARLY_ABORT_EN
          hit_seen <= 1'b1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_nonce_scheduler.sv
// Directed bench for nonce_scheduler: sweep, hits, backpressure, abort,
// outstanding limit and mid-job reset.
module tb_nonce_scheduler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sr_full, b_sr_full;
  logic [351:0] sr_data;
  logic         core_ready, rv, rh, abort;
  logic [31:0]  rn;

  logic         sr_read, core_valid, found_valid, job_done;
  logic [351:0] core_data;
  logic [31:0]  found_nonce;
  logic [7:0]   hit_count;

  logic         b_sr_read, b_core_valid, b_found_valid, b_job_done;
  logic [351:0] b_core_data;
  logic [31:0]  b_found_nonce;
  logic [7:0]   b_hit_count;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  logic [351:0] hdr1, hdr2, hdr3;

  always #5 clk = ~clk;

  nonce_scheduler #(
    .NONCE_LAST(32'd3),
    .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .sr_full(sr_full), .sr_data(sr_data), .sr_read(sr_read),
    .core_valid(core_valid), .core_ready(core_ready), .core_data(core_data),
    .core_result_valid(rv), .core_hit(rh), .core_result_nonce(rn),
    .abort(abort),
    .found_valid(found_valid), .found_nonce(found_nonce),
    .job_done(job_done), .hit_count(hit_count)
  );

  nonce_scheduler #(
    .NONCE_LAST(32'd15),
    .MAX_OUTSTANDING(2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n),
    .sr_full(b_sr_full), .sr_data(sr_data), .sr_read(b_sr_read),
    .core_valid(b_core_valid), .core_ready(core_ready), .core_data(b_core_data),
    .core_result_valid(rv), .core_hit(rh), .core_result_nonce(rn),
    .abort(abort),
    .found_valid(b_found_valid), .found_nonce(b_found_nonce),
    .job_done(b_job_done), .hit_count(b_hit_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sr_full = 1'b1; b_sr_full = 1'b0; sr_data = hdr1;
    core_ready = 1'b1; rv = 1'b0; rh = 1'b0; rn = '0; abort = 1'b0;
    #3;
    tot_cnt++; if (sr_read !== 1'b0) $display("FAIL rst_sr_read: got %b expected 0", sr_read); else pass_cnt++;
    tot_cnt++; if (core_valid !== 1'b0) $display("FAIL rst_core_valid: got %b expected 0", core_valid); else pass_cnt++;
    tot_cnt++; if (found_valid !== 1'b0) $display("FAIL rst_found_valid: got %b expected 0", found_valid); else pass_cnt++;
    tot_cnt++; if (job_done !== 1'b0) $display("FAIL rst_job_done: got %b expected 0", job_done); else pass_cnt++;
    tot_cnt++; if (hit_count !== 8'd0) $display("FAIL rst_hit_count: got %0d expected 0", hit_count); else pass_cnt++;
    tot_cnt++; if (found_nonce !== 32'd0) $display("FAIL rst_found_nonce: got %0h expected 0", found_nonce); else pass_cnt++;
    tot_cnt++; if (core_data !== 352'd0) $display("FAIL rst_core_data: got %0h expected 0", core_data); else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; sr_full = 1'b0;
  endtask

  task automatic test_sweep();
    logic [8:1] ev, jd;
    ev = 8'b0000_1111;
    jd = 8'b0100_0000;
    tick(); sr_data = hdr1; sr_full = 1'b1; core_ready = 1'b1; #2;
    tot_cnt++; if (sr_read !== 1'b1) $display("FAIL sweep_sr_read: got %b expected 1", sr_read); else pass_cnt++;
    for (int k = 1; k <= 8; k++) begin
      tick(); sr_full = 1'b0; rv = (k >= 3 && k <= 6); rh = 1'b0; rn = 32'(k - 3); #2;
      tot_cnt++; if (core_valid !== ev[k]) $display("FAIL sweep_valid[%0d]: got %b expected %b", k, core_valid, ev[k]); else pass_cnt++;
      if (ev[k]) begin
        tot_cnt++;
        if (core_data !== {hdr1[351:32], 32'(k - 1)})
          $display("FAIL sweep_data[%0d]: got %0h expected nonce %0d", k, core_data, k - 1);
        else pass_cnt++;
      end
      tot_cnt++; if (job_done !== jd[k]) $display("FAIL sweep_done[%0d]: got %b expected %b", k, job_done, jd[k]); else pass_cnt++;
      tot_cnt++; if (sr_read !== 1'b0) $display("FAIL sweep_sr_read[%0d]: got %b expected 0", k, sr_read); else pass_cnt++;
      tot_cnt++; if (found_valid !== 1'b0) $display("FAIL sweep_found[%0d]: got %b expected 0", k, found_valid); else pass_cnt++;
    end
    tot_cnt++; if (hit_count !== 8'd0) $display("FAIL sweep_hit_count: got %0d expected 0", hit_count); else pass_cnt++;
  endtask

  task automatic test_hits();
    logic [8:1]  ev, jd, fv;
    logic [7:0]  hc;
    logic [31:0] fn_last;
`ifdef NONCE_SCHEDULER_EARLY_ABORT_EN
    ev = 8'b0000_0111; jd = 8'b0010_0000; fv = 8'b0001_0000; hc = 8'd1; fn_last = 32'd1;
`else
    ev = 8'b0000_1111; jd = 8'b0100_0000; fv = 8'b0101_0000; hc = 8'd2; fn_last = 32'd3;
`endif
    tick(); sr_data = hdr2; sr_full = 1'b1; core_ready = 1'b1; #2;
    tot_cnt++; if (sr_read !== 1'b1) $display("FAIL hits_sr_read: got %b expected 1", sr_read); else pass_cnt++;
    for (int k = 1; k <= 8; k++) begin
      tick(); sr_full = 1'b0; rv = (k >= 3 && k <= 6); rh = (k == 4 || k == 6); rn = 32'(k - 3); #2;
      tot_cnt++; if (core_valid !== ev[k]) $display("FAIL hits_valid[%0d]: got %b expected %b", k, core_valid, ev[k]); else pass_cnt++;
      if (ev[k]) begin
        tot_cnt++;
        if (core_data[31:0] !== 32'(k - 1))
          $display("FAIL hits_nonce[%0d]: got %0d expected %0d", k, core_data[31:0], k - 1);
        else pass_cnt++;
      end
      tot_cnt++; if (job_done !== jd[k]) $display("FAIL hits_done[%0d]: got %b expected %b", k, job_done, jd[k]); else pass_cnt++;
      tot_cnt++; if (found_valid !== fv[k]) $display("FAIL hits_found[%0d]: got %b expected %b", k, found_valid, fv[k]); else pass_cnt++;
      if (fv[k]) begin
        tot_cnt++;
        if (found_nonce !== ((k == 5) ? 32'd1 : 32'd3))
          $display("FAIL hits_fnonce[%0d]: got %0d expected %0d", k, found_nonce, (k == 5) ? 1 : 3);
        else pass_cnt++;
      end
    end
    rv = 1'b0; rh = 1'b0;
    tot_cnt++; if (hit_count !== hc) $display("FAIL hits_count: got %0d expected %0d", hit_count, hc); else pass_cnt++;
    tot_cnt++; if (found_nonce !== fn_last) $display("FAIL hits_fnonce_hold: got %0d expected %0d", found_nonce, fn_last); else pass_cnt++;
  endtask

  task automatic test_reset_midjob();
    tick(); sr_data = hdr2; sr_full = 1'b1; core_ready = 1'b1; rv = 1'b0; rh = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick(); sr_full = 1'b0; #2;
      tot_cnt++;
      if (core_valid !== 1'b1 || core_data[31:0] !== 32'(k - 1))
        $display("FAIL mid_issue[%0d]: got v=%b n=%0d expected v=1 n=%0d", k, core_valid, core_data[31:0], k - 1);
      else pass_cnt++;
    end
    tick(); core_ready = 1'b0; #2;
    tot_cnt++; if (core_valid !== 1'b1) $display("FAIL mid_valid3: got %b expected 1", core_valid); else pass_cnt++;
    #1; rst_n = 1'b0; sr_full = 1'b1; #1;
    tot_cnt++; if (sr_read !== 1'b0) $display("FAIL mid_rst_sr_read: got %b expected 0", sr_read); else pass_cnt++;
    tot_cnt++; if (core_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b expected 0", core_valid); else pass_cnt++;
    tot_cnt++; if (found_valid !== 1'b0) $display("FAIL mid_rst_found: got %b expected 0", found_valid); else pass_cnt++;
    tot_cnt++; if (job_done !== 1'b0) $display("FAIL mid_rst_done: got %b expected 0", job_done); else pass_cnt++;
    tot_cnt++; if (found_nonce !== 32'd0) $display("FAIL mid_rst_fnonce: got %0h expected 0", found_nonce); else pass_cnt++;
    tot_cnt++; if (core_data !== 352'd0) $display("FAIL mid_rst_data: got %0h expected 0", core_data); else pass_cnt++;
    tick(); rst_n = 1'b1; sr_full = 1'b0; rv = 1'b1; rh = 1'b1; rn = 32'd5; core_ready = 1'b1; #2;
    tot_cnt++; if (sr_read !== 1'b0) $display("FAIL mid_rel_sr_read: got %b expected 0", sr_read); else pass_cnt++;
    tick(); rv = 1'b0; rh = 1'b0; sr_full = 1'b1; sr_data = hdr3; #2;
    tot_cnt++; if (found_valid !== 1'b0) $display("FAIL mid_stray_found: got %b expected 0", found_valid); else pass_cnt++;
    tot_cnt++; if (sr_read !== 1'b1) $display("FAIL mid_new_sr_read: got %b expected 1", sr_read); else pass_cnt++;
    tick(); sr_full = 1'b0; #2;
    tot_cnt++;
    if (core_valid !== 1'b1 || core_data !== {hdr3[351:32], 32'd0})
      $display("FAIL mid_new_job: got v=%b d=%0h expected v=1 nonce 0", core_valid, core_data);
    else pass_cnt++;
    tick(); abort = 1'b1; #2;
    tot_cnt++; if (core_valid !== 1'b0) $display("FAIL mid_abort_valid: got %b expected 0", core_valid); else pass_cnt++;
    tot_cnt++; if (core_data[31:0] !== 32'd1) $display("FAIL mid_abort_nonce: got %0d expected 1", core_data[31:0]); else pass_cnt++;
    tick(); abort = 1'b0; rv = 1'b1; rn = 32'd0; #2;
    tot_cnt++; if (job_done !== 1'b0) $display("FAIL mid_drain_done: got %b expected 0", job_done); else pass_cnt++;
    tick(); rv = 1'b0; #2;
    tot_cnt++; if (job_done !== 1'b1) $display("FAIL mid_job_done: got %b expected 1", job_done); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    tick(); sr_data = hdr1; sr_full = 1'b1; core_ready = 1'b1; #2;
    tot_cnt++; if (sr_read !== 1'b1) $display("FAIL bp_sr_read: got %b expected 1", sr_read); else pass_cnt++;
    tick(); sr_full = 1'b0; #2;
    tot_cnt++;
    if (core_valid !== 1'b1 || core_data[31:0] !== 32'd0)
      $display("FAIL bp_first: got v=%b n=%0d expected v=1 n=0", core_valid, core_data[31:0]);
    else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      tick(); core_ready = 1'b0; #2;
      tot_cnt++;
      if (core_valid !== 1'b1 || core_data !== {hdr1[351:32], 32'd1})
        $display("FAIL bp_stall[%0d]: got v=%b d=%0h expected v=1 nonce 1", k, core_valid, core_data);
      else pass_cnt++;
    end
    tick(); abort = 1'b1; #2;
    tot_cnt++; if (core_valid !== 1'b0) $display("FAIL bp_abort_valid: got %b expected 0", core_valid); else pass_cnt++;
    tick(); abort = 1'b0; rv = 1'b1; rn = 32'd0; #2;
    tot_cnt++; if (core_valid !== 1'b0) $display("FAIL bp_drain_valid: got %b expected 0", core_valid); else pass_cnt++;
    tot_cnt++; if (job_done !== 1'b0) $display("FAIL bp_drain_done: got %b expected 0", job_done); else pass_cnt++;
    tick(); rv = 1'b0; #2;
    tot_cnt++; if (job_done !== 1'b1) $display("FAIL bp_job_done: got %b expected 1", job_done); else pass_cnt++;
    tot_cnt++; if (hit_count !== 8'd0) $display("FAIL bp_hit_count: got %0d expected 0", hit_count); else pass_cnt++;
    tick(); core_ready = 1'b1; #2;
    tot_cnt++; if (job_done !== 1'b0) $display("FAIL bp_done_pulse: got %b expected 0", job_done); else pass_cnt++;
  endtask

  task automatic test_max_outstanding();
    logic [8:1]  ev;
    logic [31:0] en;
    ev = 8'b0010_0011;
    tick(); b_sr_full = 1'b1; sr_data = hdr2; core_ready = 1'b1; #2;
    tot_cnt++; if (b_sr_read !== 1'b1) $display("FAIL max_sr_read: got %b expected 1", b_sr_read); else pass_cnt++;
    for (int k = 1; k <= 8; k++) begin
      tick(); b_sr_full = 1'b0; rv = (k == 5); rn = 32'd0; #2;
      tot_cnt++; if (b_core_valid !== ev[k]) $display("FAIL max_valid[%0d]: got %b expected %b", k, b_core_valid, ev[k]); else pass_cnt++;
      if (ev[k]) begin
        en = (k == 1) ? 32'd0 : (k == 2) ? 32'd1 : 32'd2;
        tot_cnt++;
        if (b_core_data[31:0] !== en) $display("FAIL max_nonce[%0d]: got %0d expected %0d", k, b_core_data[31:0], en);
        else pass_cnt++;
      end
      tot_cnt++; if (b_found_valid !== 1'b0) $display("FAIL max_found[%0d]: got %b expected 0", k, b_found_valid); else pass_cnt++;
    end
    tick(); rv = 1'b0; abort = 1'b1;
    tick(); abort = 1'b0; rv = 1'b1; rn = 32'd1;
    tick(); rn = 32'd2;
    tick(); rv = 1'b0; #2;
    tot_cnt++; if (b_job_done !== 1'b1) $display("FAIL max_job_done: got %b expected 1", b_job_done); else pass_cnt++;
    tot_cnt++; if (b_hit_count !== 8'd0) $display("FAIL max_hit_count: got %0d expected 0", b_hit_count); else pass_cnt++;
    tot_cnt++; if (b_found_nonce !== 32'd0) $display("FAIL max_fnonce: got %0d expected 0", b_found_nonce); else pass_cnt++;
    tot_cnt++; if (job_done !== 1'b0) $display("FAIL max_idle_dut: got %b expected 0", job_done); else pass_cnt++;
  endtask

  initial begin
    hdr1 = {11{32'hDEAD_BEEF}};
    hdr2 = {11{32'h0BAD_F00D}};
    hdr3 = {11{32'h1357_9BDF}};
    test_reset();
    test_sweep();
    test_hits();
    test_reset_midjob();
    test_backpressure();
    test_max_outstanding();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
